face_box_detect: RTL and testbench

//   Consumes the binarised, eroded/dilated skin-mask stream (0x00/0xFF pixels

---
 rtl/face_box_detect.sv | 229 ++++++++++++++++++++++
 tb/tb_face_box_detect.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_box_detect.sv
// ----------------------------------------------------------------------------
// face_box_detect
//   Sink for the binarised skin-mask stream. For every frame it tracks the
//   bounding box and the number of foreground pixels, then publishes them on
//   the next frame edge so the overlay stage can draw a box around the face.
//
// Ports
//   clk          pixel clock (the only clock)
//   rst          synchronous reset, active-high
//   bina_hsync   line sync; registered for debug only
//   bina_vsync   frame sync; its rising edge marks the frame boundary
//   bina_de      active-pixel enable
//   bina_data    mask pixel, bit7 = foreground
//   box_x_min/box_x_max/box_y_min/box_y_max
//                bounding box of the last frame that met MIN_PIX
//   box_pix_cnt  foreground count of the last completed frame
//   box_valid    last completed frame met MIN_PIX
//   frame_done   one-cycle pulse when the outputs above update
// ----------------------------------------------------------------------------
module face_box_detect #(
    parameter logic [11:0] H_DISP  = 12'd480,
    parameter logic [11:0] V_DISP  = 12'd272,
    parameter logic [18:0] MIN_PIX = 19'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bina_hsync,
    input  logic        bina_vsync,
    input  logic        bina_de,
    input  logic [7:0]  bina_data,
    output logic [11:0] box_x_min,
    output logic [11:0] box_x_max,
    output logic [11:0] box_y_min,
    output logic [11:0] box_y_max,
    output logic [18:0] box_pix_cnt,
    output logic        box_valid,
    output logic        frame_done
);

    localparam logic [11:0] X_LAST = H_DISP - 12'd1;
    localparam logic [11:0] Y_LAST = V_DISP - 12'd1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Input edge detection
    // ------------------------------------------------------------------------
    logic r_vs_d;
    logic r_de_d;
    logic r_hs_d;
    logic w_fe;
    logic w_de_fall;
    logic w_fg;
    logic w_unused_dbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
            r_hs_d <= 1'b0;
        end else begin
            r_vs_d <= bina_vsync;
            r_de_d <= bina_de;
            r_hs_d <= bina_hsync;
        end
    end

    assign w_fe      = bina_vsync & ~r_vs_d;
    assign w_de_fall = ~bina_de & r_de_d;
    assign w_fg      = bina_de & bina_data[7];

    // Registered hsync and the low mask bits carry no function here.
    assign w_unused_dbg = ^{r_hs_d, bina_data[6:0]};

    // ------------------------------------------------------------------------
    // FSM: the first frame after reset is partial, so IDLE only arms.
    // ------------------------------------------------------------------------
    logic w_publish;
    logic w_restart;
    logic w_acc_en;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fe) w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = S_ACC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_publish = 1'b0;
        w_restart = w_fe;
        w_acc_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A pixel coincident with the arming edge already belongs
                // to the first full frame.
                w_acc_en = w_fe;
            end
            S_ACC: begin
                w_publish = w_fe;
                w_acc_en  = 1'b1;
            end
            default: begin
                w_publish = 1'b0;
                w_acc_en  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pixel coordinates (value before this cycle's update is the coordinate)
    // ------------------------------------------------------------------------
    logic [11:0] r_x_cnt;
    logic [11:0] r_y_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt <= 12'd0;
        end else if (bina_de) begin
            if (r_x_cnt != X_LAST) r_x_cnt <= r_x_cnt + 12'd1;
        end else if (w_de_fall) begin
            r_x_cnt <= 12'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_cnt <= 12'd0;
        end else if (w_fe) begin
            r_y_cnt <= 12'd0;
        end else if (w_de_fall) begin
            if (r_y_cnt != Y_LAST) r_y_cnt <= r_y_cnt + 12'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Accumulators. On a frame edge the base is the init value, so a pixel
    // in that same cycle merges into the new frame rather than the old one.
    // ------------------------------------------------------------------------
    logic [11:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic [18:0] r_pix;
    logic [11:0] w_base_x_min, w_base_x_max, w_base_y_min, w_base_y_max;
    logic [18:0] w_base_pix;
    logic [11:0] w_nxt_x_min, w_nxt_x_max, w_nxt_y_min, w_nxt_y_max;
    logic [18:0] w_nxt_pix;

    always_comb begin
        w_base_x_min = w_restart ? X_LAST : r_x_min;
        w_base_x_max = w_restart ? 12'd0  : r_x_max;
        w_base_y_min = w_restart ? Y_LAST : r_y_min;
        w_base_y_max = w_restart ? 12'd0  : r_y_max;
        w_base_pix   = w_restart ? 19'd0  : r_pix;

        w_nxt_x_min = w_base_x_min;
        w_nxt_x_max = w_base_x_max;
        w_nxt_y_min = w_base_y_min;
        w_nxt_y_max = w_base_y_max;
        w_nxt_pix   = w_base_pix;

        if (w_acc_en && w_fg) begin
            if (r_x_cnt < w_base_x_min) w_nxt_x_min = r_x_cnt;
            if (r_x_cnt > w_base_x_max) w_nxt_x_max = r_x_cnt;
            if (r_y_cnt < w_base_y_min) w_nxt_y_min = r_y_cnt;
            if (r_y_cnt > w_base_y_max) w_nxt_y_max = r_y_cnt;
            if (w_base_pix != {19{1'b1}}) w_nxt_pix = w_base_pix + 19'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_min <= X_LAST;
            r_x_max <= 12'd0;
            r_y_min <= Y_LAST;
            r_y_max <= 12'd0;
            r_pix   <= 19'd0;
        end else begin
            r_x_min <= w_nxt_x_min;
            r_x_max <= w_nxt_x_max;
            r_y_min <= w_nxt_y_min;
            r_y_max <= w_nxt_y_max;
            r_pix   <= w_nxt_pix;
        end
    end

    // ------------------------------------------------------------------------
    // Publish. The count always updates; the box only when the frame had
    // enough foreground, so a weak frame keeps the last good box on screen.
    // ------------------------------------------------------------------------
    logic w_meet;
    assign w_meet = (r_pix >= MIN_PIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_min   <= 12'd0;
            box_x_max   <= 12'd0;
            box_y_min   <= 12'd0;
            box_y_max   <= 12'd0;
            box_pix_cnt <= 19'd0;
            box_valid   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= w_publish;
            if (w_publish) begin
                box_pix_cnt <= r_pix;
                box_valid   <= w_meet;
                if (w_meet) begin
                    box_x_min <= r_x_min;
                    box_x_max <= r_x_max;
                    box_y_min <= r_y_min;
                    box_y_max <= r_y_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_face_box_detect.sv
module tb_face_box_detect;
    localparam int H  = 40;
    localparam int V  = 24;
    localparam int ML = 28;
    localparam int MP = 44;

    logic clk = 1'b0;
    logic rst, hs, vs, de;
    logic [7:0] data;
    logic [1:0][11:0] xmin, xmax, ymin, ymax;
    logic [1:0][18:0] pcnt;
    logic [1:0] valid, done;

    always #5 clk = ~clk;

    // dut 0: MIN_PIX=20, dut 1: MIN_PIX=1; both see the same stream
    face_box_detect #(.H_DISP(12'd40), .V_DISP(12'd24), .MIN_PIX(19'd20)) dut_a (
        .clk(clk), .rst(rst), .bina_hsync(hs), .bina_vsync(vs), .bina_de(de),
        .bina_data(data), .box_x_min(xmin[0]), .box_x_max(xmax[0]),
        .box_y_min(ymin[0]), .box_y_max(ymax[0]), .box_pix_cnt(pcnt[0]),
        .box_valid(valid[0]), .frame_done(done[0]));

    face_box_detect #(.H_DISP(12'd40), .V_DISP(12'd24), .MIN_PIX(19'd1)) dut_b (
        .clk(clk), .rst(rst), .bina_hsync(hs), .bina_vsync(vs), .bina_de(de),
        .bina_data(data), .box_x_min(xmin[1]), .box_x_max(xmax[1]),
        .box_y_min(ymin[1]), .box_y_max(ymax[1]), .box_pix_cnt(pcnt[1]),
        .box_valid(valid[1]), .frame_done(done[1]));

    int errs = 0;
    int checks = 0;

    // reference model state
    bit mask [ML][MP];
    int minp [2] = '{20, 1};
    bit armed;
    int f_cnt, f_x0, f_x1, f_y0, f_y1;
    int e_x0 [2], e_x1 [2], e_y0 [2], e_y1 [2], e_cnt [2];
    bit e_val [2];

    typedef struct {
        int x0, x1, y0, y1;
        int cnt;
        bit val;
        int bx0, bx1, by0, by1;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_stats();
        f_cnt = 0; f_x0 = 1 << 30; f_x1 = -1; f_y0 = 1 << 30; f_y1 = -1;
    endtask

    task automatic model_reset();
        armed = 1'b0;
        clr_stats();
        for (int d = 0; d < 2; d++) begin
            e_x0[d] = 0; e_x1[d] = 0; e_y0[d] = 0; e_y1[d] = 0;
            e_cnt[d] = 0; e_val[d] = 1'b0;
        end
    endtask

    // coordinates saturate at the last column / last line
    task automatic model_pix(input int pi, input int li);
        int x, y;
        if (!armed) return;
        x = (pi < H) ? pi : H - 1;
        y = (li < V) ? li : V - 1;
        f_cnt++;
        if (x < f_x0) f_x0 = x;
        if (x > f_x1) f_x1 = x;
        if (y < f_y0) f_y0 = y;
        if (y > f_y1) f_y1 = y;
    endtask

    task automatic chk_outs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d x_min", tag, d), 32'(xmin[d]), e_x0[d]);
            chk($sformatf("%s d%0d x_max", tag, d), 32'(xmax[d]), e_x1[d]);
            chk($sformatf("%s d%0d y_min", tag, d), 32'(ymin[d]), e_y0[d]);
            chk($sformatf("%s d%0d y_max", tag, d), 32'(ymax[d]), e_y1[d]);
            chk($sformatf("%s d%0d pix_cnt", tag, d), 32'(pcnt[d]), e_cnt[d]);
            chk($sformatf("%s d%0d valid", tag, d), 32'(valid[d]), 32'(e_val[d]));
        end
    endtask

    task automatic clear_mask();
        for (int l = 0; l < ML; l++)
            for (int p = 0; p < MP; p++) mask[l][p] = 1'b0;
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1);
        clear_mask();
        for (int l = y0; l <= y1; l++)
            for (int p = x0; p <= x1; p++) mask[l][p] = 1'b1;
    endtask

    task automatic fill_rand(input int pct);
        for (int l = 0; l < ML; l++)
            for (int p = 0; p < MP; p++) mask[l][p] = ($urandom_range(99) < pct);
    endtask

    task automatic drive_frame(input int nl, input int np);
        for (int li = 0; li < nl; li++) begin
            for (int pi = 0; pi < np; pi++) begin
                @(posedge clk); #1;
                de = 1'b1; hs = 1'b0;
                if (mask[li][pi]) begin
                    data = {1'b1, 7'($urandom)};
                    model_pix(pi, li);
                end else begin
                    data = {1'b0, 7'($urandom)};
                end
            end
            for (int b = 0; b < 3; b++) begin
                @(posedge clk); #1;
                de = 1'b0; data = 8'($urandom); hs = (b == 1);
            end
        end
    endtask

    task automatic vsync_pulse(input string tag);
        bit exp_done;
        @(posedge clk); #1;
        vs = 1'b1; de = 1'b0;
        exp_done = armed;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                e_cnt[d] = f_cnt;
                e_val[d] = (f_cnt >= minp[d]);
                if (e_val[d]) begin
                    e_x0[d] = f_x0; e_x1[d] = f_x1; e_y0[d] = f_y0; e_y1[d] = f_y1;
                end
            end
        end
        armed = 1'b1;
        clr_stats();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s d%0d frame_done", tag, d), 32'(done[d]), 32'(exp_done));
        chk_outs(tag);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s d%0d frame_done drop", tag, d), 32'(done[d]), 32'd0);
        @(posedge clk); #1;
        vs = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // pattern frames: rectangle per row, expectations for dut 0 (MIN_PIX=20)
        tbl[0] = '{10, 19,  5, 14, 100, 1'b1, 10, 19, 5, 14};
        tbl[1] = '{39, 39, 23, 23,   1, 1'b0, 10, 19, 5, 14};
        tbl[2] = '{ 1,  0,  0,  0,   0, 1'b0, 10, 19, 5, 14};
        tbl[3] = '{ 0, 39,  0, 23, 960, 1'b1,  0, 39, 0, 23};
        tbl[4] = '{ 0,  4,  0,  3,  20, 1'b1,  0,  4, 0,  3};
        tbl[5] = '{ 0,  3,  0,  3,  16, 1'b0,  0,  4, 0,  3};
        tbl[6] = '{ 0,  0,  0,  0,   1, 1'b0,  0,  4, 0,  3};

        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset");
        for (int d = 0; d < 2; d++) chk($sformatf("reset d%0d frame_done", d), 32'(done[d]), 32'd0);
        rst = 1'b0;

        // partial frame before the first vsync is never published
        fill_rand(20);
        drive_frame(V, H);
        vsync_pulse("arm");

        for (int i = 0; i < 7; i++) begin
            fill_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
            drive_frame(V, H);
            vsync_pulse($sformatf("row%0d", i));
            chk($sformatf("tbl%0d cnt", i), 32'(pcnt[0]), tbl[i].cnt);
            chk($sformatf("tbl%0d valid", i), 32'(valid[0]), 32'(tbl[i].val));
            chk($sformatf("tbl%0d x_min", i), 32'(xmin[0]), tbl[i].bx0);
            chk($sformatf("tbl%0d x_max", i), 32'(xmax[0]), tbl[i].bx1);
            chk($sformatf("tbl%0d y_min", i), 32'(ymin[0]), tbl[i].by0);
            chk($sformatf("tbl%0d y_max", i), 32'(ymax[0]), tbl[i].by1);
            if (i == 1) begin
                chk("corner B box", {xmin[1], xmax[1], ymin[1][7:0]}, {12'd39, 12'd39, 8'd23});
                chk("corner B y_max/valid", {ymax[1], 3'b0, valid[1]}, {12'd23, 4'b0001});
            end
            if (i == 6) begin
                chk("origin B box", {xmin[1], xmax[1], ymin[1][7:0]}, 32'd0);
                chk("origin B y_max/valid", {ymax[1], 3'b0, valid[1]}, {12'd0, 4'b0001});
            end
        end

        // oversize lines/frame: coordinates saturate at the last column/line
        clear_mask();
        mask[26][42] = 1'b1;
        mask[3][5]   = 1'b1;
        drive_frame(27, 43);
        vsync_pulse("oversize");

        for (int r = 0; r < 8; r++) begin
            int pct;
            case ($urandom_range(3))
                0: pct = 0;
                1: pct = 2;
                2: pct = 5;
                default: pct = 30;
            endcase
            fill_rand(pct);
            drive_frame(($urandom_range(1) != 0) ? V : V + 2,
                        ($urandom_range(1) != 0) ? H : H + 3);
            vsync_pulse($sformatf("rand%0d", r));
        end

        // reset in the middle of a frame while de keeps toggling
        fill_rect(2, 30, 0, 11);
        drive_frame(12, H);
        @(posedge clk); #1;
        rst = 1'b1; de = 1'b1; data = 8'hFF;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_outs($sformatf("midrst%0d", k));
            for (int d = 0; d < 2; d++)
                chk($sformatf("midrst%0d d%0d frame_done", k, d), 32'(done[d]), 32'd0);
            de = ~de;
        end
        rst = 1'b0; de = 1'b0; data = 8'h00;
        @(posedge clk); #1;
        vsync_pulse("rearm");
        fill_rect(10, 19, 5, 14);
        drive_frame(V, H);
        vsync_pulse("after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
